// File: rtl/pipelined_decode_unit_if.sv
// IF -> ID -> EX bus for the registered decode stage: valid/ready handshakes, flush,
// the decoded control bundle and the stall counter.
interface pipelined_decode_unit_if #(
  parameter int PC_W    = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) ();
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [4:0]         out_shamt;
  logic [15:0]        out_imm;
  logic [ALUOP_W-1:0] out_alu_op;
  logic [11:0]        out_ctrl;
  logic               out_illegal;
  logic [CNT_W-1:0]   stall_count;

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_alu_op, out_ctrl, out_illegal, stall_count
  );

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_alu_op, out_ctrl, out_illegal, stall_count
  );
endinterface

// File: rtl/pipelined_decode_unit.sv
// ID-stage decoder with an ID/EX output register, load-use bubble insertion,
// redirect flush, illegal-encoding flag and a saturating stall counter.
module pipelined_decode_unit #(
  parameter int PC_W            = 32,
  parameter int ALUOP_W         = 4,
  parameter int LOAD_USE_DETECT = 1,
  parameter int JAL_LINK        = 1,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipelined_decode_unit_if.slave dec_if
);

  localparam logic [11:0] C_ARITH  = 12'h800;
  localparam logic [11:0] C_JR     = 12'h400;
  localparam logic [11:0] C_JAL    = 12'h200;
  localparam logic [11:0] C_JUMP   = 12'h100;
  localparam logic [11:0] C_BNE    = 12'h080;
  localparam logic [11:0] C_ALUSRC = 12'h040;
  localparam logic [11:0] C_REGWR  = 12'h020;
  localparam logic [11:0] C_MEMWR  = 12'h010;
  localparam logic [11:0] C_MEM2RG = 12'h008;
  localparam logic [11:0] C_MEMRD  = 12'h004;
  localparam logic [11:0] C_BRANCH = 12'h002;
  localparam logic [11:0] C_REGDST = 12'h001;

  localparam logic [11:0] CTRL_RTYPE = C_ARITH | C_REGWR | C_REGDST;
  localparam logic [11:0] CTRL_ITYPE = C_ARITH | C_REGWR | C_ALUSRC;
  localparam logic [11:0] CTRL_LW    = C_MEMRD | C_MEM2RG | C_REGWR | C_ALUSRC;
  localparam logic [11:0] CTRL_SW    = C_MEMWR | C_ALUSRC;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [3:0]  alu;
    logic        illegal;
    logic [4:0]  rd;
  } dec_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [4:0]         shamt;
    logic [15:0]        imm;
    logic [ALUOP_W-1:0] alu_op;
    logic [11:0]        ctrl;
    logic               illegal;
  } payload_t;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_e;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.ctrl    = 12'h000;
    d.alu     = 4'd0;
    d.illegal = 1'b0;
    d.rd      = instr[15:11];
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          6'h20:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd0; end
          6'h22:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd1; end
          6'h24:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd2; end
          6'h25:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd3; end
          6'h2A:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd4; end
          6'h26:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd5; end
          6'h27:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd6; end
          6'h00:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd7; end
          6'h02:   begin d.ctrl = CTRL_RTYPE; d.alu = 4'd8; end
          6'h08:   d.ctrl = C_JUMP | C_JR;
          default: d.illegal = 1'b1;
        endcase
      end
      6'h08:   begin d.ctrl = CTRL_ITYPE; d.alu = 4'd0; end
      6'h0C:   begin d.ctrl = CTRL_ITYPE; d.alu = 4'd2; end
      6'h0D:   begin d.ctrl = CTRL_ITYPE; d.alu = 4'd3; end
      6'h0E:   begin d.ctrl = CTRL_ITYPE; d.alu = 4'd5; end
      6'h0A:   begin d.ctrl = CTRL_ITYPE; d.alu = 4'd4; end
      OP_LW:   d.ctrl = CTRL_LW;
      OP_SW:   d.ctrl = CTRL_SW;
      OP_BEQ:  begin d.ctrl = C_BRANCH; d.alu = 4'd1; end
      OP_BNE:  begin d.ctrl = C_BRANCH | C_BNE; d.alu = 4'd1; end
      6'h02:   d.ctrl = C_JUMP;
      6'h03: begin
        if (JAL_LINK != 0) begin
          d.ctrl = C_JUMP | C_JAL | C_REGWR;
          d.rd   = 5'd31;
        end else begin
          d.ctrl = C_JUMP | C_JAL;
        end
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_e           state_q, state_d;
  payload_t         payload_q, payload_d;
  logic             valid_q, valid_d;
  logic             lw_pend_q, lw_pend_d;
  logic [4:0]       lw_rt_q, lw_rt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [5:0] op_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic       uses_rt_s;
  logic       hazard_s;
  logic       advance_s;
  logic       in_ready_s;
  logic       bubble_s;
  logic       accept_s;
  dec_t       dec_s;

  assign op_s      = dec_if.in_instr[31:26];
  assign rs_s      = dec_if.in_instr[25:21];
  assign rt_s      = dec_if.in_instr[20:16];
  assign uses_rt_s = (op_s == OP_RTYPE) || (op_s == OP_BEQ) || (op_s == OP_BNE) || (op_s == OP_SW);
  assign hazard_s  = (LOAD_USE_DETECT != 0) && lw_pend_q && (lw_rt_q != 5'd0) &&
                     ((rs_s == lw_rt_q) || ((rt_s == lw_rt_q) && uses_rt_s));
  assign advance_s = !valid_q || dec_if.out_ready;
  assign accept_s  = dec_if.in_valid && in_ready_s;
  assign dec_s     = decode(dec_if.in_instr);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a bubble parks us in BUBBLE until the held instruction is taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dec_if.flush) begin
          state_d = ST_RUN;
        end else if (dec_if.in_valid && hazard_s && advance_s) begin
          state_d = ST_BUBBLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BUBBLE: begin
        if (dec_if.flush) begin
          state_d = ST_RUN;
        end else if (dec_if.in_valid && advance_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_BUBBLE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: input handshake and bubble strobe
  always_comb begin
    in_ready_s = 1'b0;
    bubble_s   = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready_s = advance_s && !hazard_s && !dec_if.flush;
        bubble_s   = dec_if.in_valid && hazard_s && advance_s && !dec_if.flush;
      end
      ST_BUBBLE: begin
        in_ready_s = advance_s && !dec_if.flush;
        bubble_s   = 1'b0;
      end
      default: begin
        in_ready_s = 1'b0;
        bubble_s   = 1'b0;
      end
    endcase
  end

  // ID/EX register, hazard tracker and stall counter next state
  always_comb begin
    valid_d   = valid_q;
    lw_pend_d = lw_pend_q;
    lw_rt_d   = lw_rt_q;
    stall_d   = stall_q;
    payload_d = payload_q;
    if (dec_if.flush) begin
      valid_d   = 1'b0;
      lw_pend_d = 1'b0;
    end else if (bubble_s) begin
      valid_d   = 1'b0;
      lw_pend_d = 1'b0;
      if (stall_q == {CNT_W{1'b1}}) begin
        stall_d = stall_q;
      end else begin
        stall_d = stall_q + CNT_W'(1'b1);
      end
    end else if (accept_s) begin
      valid_d           = 1'b1;
      lw_pend_d         = (op_s == OP_LW);
      lw_rt_d           = rt_s;
      payload_d.pc      = dec_if.in_pc;
      payload_d.rs      = rs_s;
      payload_d.rt      = rt_s;
      payload_d.rd      = dec_s.rd;
      payload_d.shamt   = dec_if.in_instr[10:6];
      payload_d.imm     = dec_if.in_instr[15:0];
      payload_d.alu_op  = ALUOP_W'(dec_s.alu);
      payload_d.ctrl    = dec_s.ctrl;
      payload_d.illegal = dec_s.illegal;
    end else if (advance_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      lw_pend_q <= 1'b0;
      lw_rt_q   <= 5'd0;
      stall_q   <= {CNT_W{1'b0}};
      payload_q <= {$bits(payload_t){1'b0}};
    end else begin
      valid_q   <= valid_d;
      lw_pend_q <= lw_pend_d;
      lw_rt_q   <= lw_rt_d;
      stall_q   <= stall_d;
      payload_q <= payload_d;
    end
  end

  assign dec_if.in_ready    = in_ready_s;
  assign dec_if.out_valid   = valid_q;
  assign dec_if.out_pc      = payload_q.pc;
  assign dec_if.out_rs      = payload_q.rs;
  assign dec_if.out_rt      = payload_q.rt;
  assign dec_if.out_rd      = payload_q.rd;
  assign dec_if.out_shamt   = payload_q.shamt;
  assign dec_if.out_imm     = payload_q.imm;
  assign dec_if.out_alu_op  = payload_q.alu_op;
  assign dec_if.out_ctrl    = payload_q.ctrl;
  assign dec_if.out_illegal = payload_q.illegal;
  assign dec_if.stall_count = stall_q;

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Directed and randomized bench for pipelined_decode_unit against a transaction-level
// reference model (mnemonic decode, held-slot queue, last-load tracker).
module tb_pipelined_decode_unit;
  localparam int PC_W    = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 2;
  localparam int SAT     = 3;

  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A,
                                      6'h23, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
  localparam logic [5:0] FNS [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27,
                                      6'h00, 6'h02, 6'h08, 6'h3F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_decode_unit_if #(.PC_W(PC_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dif ();

  pipelined_decode_unit #(
    .PC_W(PC_W), .ALUOP_W(ALUOP_W), .LOAD_USE_DETECT(1), .JAL_LINK(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dec_if(dif)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  bit           m_valid;
  logic [127:0] m_out;
  bit           m_pend;
  logic [4:0]   m_rt;
  int           m_stall;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string mnem(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: return "add";   6'h22: return "sub";
          6'h24: return "and";   6'h25: return "or";
          6'h2A: return "slt";   6'h26: return "xor";
          6'h27: return "nor";   6'h00: return "sll";
          6'h02: return "srl";   6'h08: return "jr";
          default: return "ill";
        endcase
      end
      6'h08: return "addi";  6'h0C: return "andi";
      6'h0D: return "ori";   6'h0E: return "xori";
      6'h0A: return "slti";  6'h23: return "lw";
      6'h2B: return "sw";    6'h04: return "beq";
      6'h05: return "bne";   6'h02: return "j";
      6'h03: return "jal";
      default: return "ill";
    endcase
  endfunction

  function automatic bit is_ralu(input string m);
    return m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt" ||
           m == "xor" || m == "nor" || m == "sll" || m == "srl";
  endfunction

  function automatic bit is_imm(input string m);
    return m == "addi" || m == "andi" || m == "ori" || m == "xori" || m == "slti";
  endfunction

  function automatic logic [3:0] alu_of(input string m);
    if (m == "sub" || m == "beq" || m == "bne") return 4'd1;
    if (m == "and" || m == "andi") return 4'd2;
    if (m == "or"  || m == "ori")  return 4'd3;
    if (m == "slt" || m == "slti") return 4'd4;
    if (m == "xor" || m == "xori") return 4'd5;
    if (m == "nor") return 4'd6;
    if (m == "sll") return 4'd7;
    if (m == "srl") return 4'd8;
    return 4'd0;
  endfunction

  function automatic logic [11:0] ctrl_of(input string m);
    logic [11:0] c;
    c = 12'h000;
    c[11] = is_ralu(m) || is_imm(m);
    c[10] = (m == "jr");
    c[9]  = (m == "jal");
    c[8]  = (m == "jr") || (m == "j") || (m == "jal");
    c[7]  = (m == "bne");
    c[6]  = is_imm(m) || (m == "lw") || (m == "sw");
    c[5]  = is_ralu(m) || is_imm(m) || (m == "lw") || (m == "jal");
    c[4]  = (m == "sw");
    c[3]  = (m == "lw");
    c[2]  = (m == "lw");
    c[1]  = (m == "beq") || (m == "bne");
    c[0]  = is_ralu(m);
    return c;
  endfunction

  function automatic logic [127:0] exp_bundle(input logic [31:0] ins, input logic [31:0] pc);
    string m;
    logic [4:0] rd;
    m  = mnem(ins);
    rd = (m == "jal") ? 5'd31 : ins[15:11];
    return 128'({pc, ins[25:21], ins[20:16], rd, ins[10:6], ins[15:0],
                 alu_of(m), ctrl_of(m), (m == "ill")});
  endfunction

  function automatic logic [127:0] dut_bundle();
    return 128'({dif.out_pc, dif.out_rs, dif.out_rt, dif.out_rd, dif.out_shamt, dif.out_imm,
                 dif.out_alu_op, dif.out_ctrl, dif.out_illegal});
  endfunction

  function automatic bit reads_rt(input logic [31:0] ins);
    return ins[31:26] == 6'h00 || ins[31:26] == 6'h04 || ins[31:26] == 6'h05 || ins[31:26] == 6'h2B;
  endfunction

  // One clock: check the combinational handshake, advance the model, check the register
  task automatic tick();
    bit adv, haz, exp_rdy;
    #1;
    adv = !m_valid || dif.out_ready;
    haz = m_pend && (m_rt != 5'd0) &&
          (dif.in_instr[25:21] == m_rt || (dif.in_instr[20:16] == m_rt && reads_rt(dif.in_instr)));
    exp_rdy = adv && !haz && !dif.flush;
    if (rst_n) chk("in_ready", 128'(dif.in_ready), 128'(exp_rdy));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_pend = 1'b0; m_rt = 5'd0; m_stall = 0;
    end else if (dif.flush) begin
      m_valid = 1'b0; m_pend = 1'b0;
    end else if (dif.in_valid && adv && haz) begin
      m_valid = 1'b0; m_pend = 1'b0;
      if (m_stall < SAT) m_stall++;
    end else if (dif.in_valid && adv) begin
      m_valid = 1'b1;
      m_out   = exp_bundle(dif.in_instr, dif.in_pc);
      m_pend  = (dif.in_instr[31:26] == 6'h23);
      m_rt    = dif.in_instr[20:16];
    end else if (adv) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 128'(dif.out_valid), 128'(m_valid));
    chk("stall_count", 128'(dif.stall_count), 128'(m_stall));
    if (m_valid) chk("out_bundle", dut_bundle(), m_out);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    dif.in_valid  = v;
    dif.in_instr  = ins;
    dif.in_pc     = pc;
    dif.out_ready = ordy;
    dif.flush     = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    op = OPS[$urandom_range(0, 15)];
    fn = (op == 6'h00) ? FNS[$urandom_range(0, 10)] : 6'($urandom());
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 5'($urandom()), fn};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_valid = 1'b0; m_pend = 1'b0; m_rt = 5'd0; m_stall = 0; m_out = 128'd0;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_ctrl", 128'(dif.out_ctrl), 128'd0);
    chk("rst_bundle", dut_bundle(), 128'd0);

    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("rst_in_ready", 128'(dif.in_ready), 128'd1);
    tick();

    drive(1'b1, 32'h00221820, 32'h100, 1'b1, 1'b0);
    tick();
    chk("add_ctrl", 128'(dif.out_ctrl), 128'h821);
    chk("add_alu", 128'(dif.out_alu_op), 128'd0);
    chk("add_rd", 128'(dif.out_rd), 128'd3);

    drive(1'b1, 32'h8C220000, 32'h104, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h00441820, 32'h108, 1'b1, 1'b0);
    tick();
    chk("bubble_gap", 128'(dif.out_valid), 128'd0);
    tick();
    chk("lu_stall", 128'(dif.stall_count), 128'd1);

    drive(1'b1, 32'h00622022, 32'h10C, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h00A63825, 32'h110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_pc", 128'(dif.out_pc), 128'h10C);
    dif.out_ready = 1'b1;
    tick();
    chk("release_pc", 128'(dif.out_pc), 128'h110);

    drive(1'b1, 32'h8C220000, 32'h114, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00441820, 32'h118, 1'b0, 1'b1);
    tick();
    chk("flush_valid", 128'(dif.out_valid), 128'd0);
    dif.flush = 1'b0;
    tick();
    chk("flush_nostall", 128'(dif.out_pc), 128'h118);
    dif.out_ready = 1'b1;

    drive(1'b1, 32'hFC000000, 32'h11C, 1'b1, 1'b0);
    tick();
    chk("ill_flag", 128'(dif.out_illegal), 128'd1);
    chk("ill_ctrl", 128'(dif.out_ctrl), 128'd0);
    drive(1'b1, 32'h0C000010, 32'h120, 1'b1, 1'b0);
    tick();
    chk("jal_ctrl", 128'(dif.out_ctrl), 128'h320);
    chk("jal_rd", 128'(dif.out_rd), 128'd31);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8C220000, 32'h200, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h00441820, 32'h204, 1'b1, 1'b0);
      tick(); tick();
    end
    chk("stall_sat", 128'(dif.stall_count), 128'd3);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom(),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
